// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - two-port round-robin arbiter in front of the cache CPU port
// Holds the granted request stable through misses and keeps per-port access/miss counters.
module cache_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_done,
  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_rd_req,
  output logic              c_wr_req,
  output logic [DATA_W-1:0] c_wr_data,
  input  logic              c_miss,
  input  logic [DATA_W-1:0] c_rd_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  p0_acc_cnt,
  output logic [CNT_W-1:0]  p0_miss_cnt,
  output logic [CNT_W-1:0]  p1_acc_cnt,
  output logic [CNT_W-1:0]  p1_miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next_state;
  logic              r_owner;
  logic              r_last;
  logic              r_first;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_p0_acc;
  logic [CNT_W-1:0]  r_p0_miss;
  logic [CNT_W-1:0]  r_p1_acc;
  logic [CNT_W-1:0]  r_p1_miss;
  logic              w_grant;
  logic              w_grant_port;
  logic              w_first_acc;

  function automatic logic [CNT_W-1:0] f_cnt_next(input logic [CNT_W-1:0] cnt,
                                                   input logic inc, input logic clr);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (clr) begin
      res = '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      res = cnt + CNT_ONE;
    end
    return res;
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_port = 1'b0;
    c_rd_req     = 1'b0;
    c_wr_req     = 1'b0;
    p0_done      = 1'b0;
    p1_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the port that was not served last wins
        if (p0_valid && p1_valid) begin
          w_grant      = 1'b1;
          w_grant_port = ~r_last;
        end else if (p0_valid) begin
          w_grant      = 1'b1;
          w_grant_port = 1'b0;
        end else if (p1_valid) begin
          w_grant      = 1'b1;
          w_grant_port = 1'b1;
        end
        if (w_grant) begin
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        c_rd_req = ~r_we;
        c_wr_req = r_we;
        if (!c_miss) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        p0_done      = ~r_owner;
        p1_done      = r_owner;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_first <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_grant) begin
        r_owner <= w_grant_port;
        r_addr  <= w_grant_port ? p1_addr : p0_addr;
        r_we    <= w_grant_port & p1_we;
        r_wdata <= w_grant_port ? p1_wdata : r_wdata;
        r_first <= 1'b1;
      end
      if (r_state == S_ACCESS) begin
        r_first <= 1'b0;
      end
      if (r_state == S_DONE) begin
        r_last <= r_owner;
        if (!r_we) begin
          r_rdata <= c_rd_data;
        end
      end
    end
  end

  // Accesses and misses are counted once per request, in its first ACCESS cycle
  assign w_first_acc = (r_state == S_ACCESS) && r_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0_acc  <= '0;
      r_p0_miss <= '0;
      r_p1_acc  <= '0;
      r_p1_miss <= '0;
    end else begin
      r_p0_acc  <= f_cnt_next(r_p0_acc,  w_first_acc && !r_owner,           cnt_clr);
      r_p0_miss <= f_cnt_next(r_p0_miss, w_first_acc && !r_owner && c_miss, cnt_clr);
      r_p1_acc  <= f_cnt_next(r_p1_acc,  w_first_acc &&  r_owner,           cnt_clr);
      r_p1_miss <= f_cnt_next(r_p1_miss, w_first_acc &&  r_owner && c_miss, cnt_clr);
    end
  end

  assign c_addr      = r_addr;
  assign c_wr_data   = r_wdata;
  // The cache's read register is valid during DONE; afterwards the captured copy holds
  assign rdata       = (r_state == S_DONE && !r_we) ? c_rd_data : r_rdata;
  assign p0_acc_cnt  = r_p0_acc;
  assign p0_miss_cnt = r_p0_miss;
  assign p1_acc_cnt  = r_p1_acc;
  assign p1_miss_cnt = r_p1_miss;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - self-checking bench for cache_port_arbiter
// Directed vector table, hand-written corner sequences and a randomized two-requester run.
`timescale 1ns/1ps
module tb_cache_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int FILL_LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          p0_valid = 1'b0, p1_valid = 1'b0, p1_we = 1'b0, cnt_clr = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_done, p1_done, c_rd_req, c_wr_req, c_miss;
  logic [DW-1:0] rdata, c_wr_data, c_rd_data;
  logic [AW-1:0] c_addr;
  logic [31:0]   p0_acc_cnt, p0_miss_cnt, p1_acc_cnt, p1_miss_cnt;

  cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_done(p0_done),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_done(p1_done),
    .rdata(rdata), .c_addr(c_addr), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req), .c_wr_data(c_wr_data),
    .c_miss(c_miss), .c_rd_data(c_rd_data), .cnt_clr(cnt_clr),
    .p0_acc_cnt(p0_acc_cnt), .p0_miss_cnt(p0_miss_cnt), .p1_acc_cnt(p1_acc_cnt), .p1_miss_cnt(p1_miss_cnt)
  );

  logic        s_p0_valid = 1'b0, s_cnt_clr = 1'b0;
  logic        s_p0_done, s_p1_done, s_rd_req, s_wr_req;
  logic [31:0] s_rdata, s_c_addr, s_c_wr_data;
  logic [3:0]  s_p0_acc, s_p0_miss, s_p1_acc, s_p1_miss;

  cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(s_p0_valid), .p0_addr(32'h80), .p0_done(s_p0_done),
    .p1_valid(1'b0), .p1_we(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0), .p1_done(s_p1_done),
    .rdata(s_rdata), .c_addr(s_c_addr), .c_rd_req(s_rd_req), .c_wr_req(s_wr_req), .c_wr_data(s_c_wr_data),
    .c_miss(1'b0), .c_rd_data(32'h5A5A_0001), .cnt_clr(s_cnt_clr),
    .p0_acc_cnt(s_p0_acc), .p0_miss_cnt(s_p0_miss), .p1_acc_cnt(s_p1_acc), .p1_miss_cnt(s_p1_miss)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Cache model: word-indexed lines, a miss stays up for FILL_LAT cycles, then the line is present
  logic [DW-1:0] cmem [256];
  logic          present [256];
  int            fill_cnt;
  logic          pl_en = 1'b0;
  logic [7:0]    pl_idx = '0;
  logic [7:0]    c_idx;
  assign c_idx  = c_addr[9:2];
  assign c_miss = (c_rd_req || c_wr_req) && !present[c_idx];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        present[i] <= 1'b0;
        cmem[i]    <= init_word(i);
      end
      fill_cnt  <= 0;
      c_rd_data <= '0;
    end else begin
      if (pl_en) present[pl_idx] <= 1'b1;
      if (c_rd_req || c_wr_req) begin
        if (!present[c_idx]) begin
          if (fill_cnt == FILL_LAT-1) begin
            present[c_idx] <= 1'b1;
            fill_cnt       <= 0;
          end else begin
            fill_cnt <= fill_cnt + 1;
          end
        end else if (c_wr_req) begin
          cmem[c_idx] <= c_wr_data;
        end else begin
          c_rd_data <= cmem[c_idx];
        end
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    p0_valid = 1'b0; p1_valid = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic preload(input logic [7:0] idx);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_access(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output int req_cyc,
                           output logic [31:0] rd);
    @(posedge clk); #1;
    if (port) begin
      p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_valid = 1'b1; p0_addr = addr;
    end
    lat = -1; req_cyc = 0; rd = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (port ? p1_done : p0_done) begin
        lat = k; rd = rdata;
        break;
      end
      if ((we ? c_wr_req : c_rd_req) && !(we ? c_rd_req : c_wr_req)) req_cyc++;
    end
    @(posedge clk); #1;
    p0_valid = 1'b0; p1_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Reference model for the randomized run
  logic [31:0] ref_mem [256];
  logic        ref_warm [256];
  int          m_acc [2];
  int          m_miss [2];
  int          m_last, m_exp, m_pending, req_fin;
  logic [31:0] rq_addr [2];
  logic        rq_we [2];
  logic [31:0] rq_wdata [2];

  task automatic monitor_step();
    int p, idx;
    if (p0_done || p1_done) begin
      p = p1_done ? 1 : 0;
      chk("rand_done_onehot", {63'b0, p0_done & p1_done}, 64'd0);
      chk("rand_rr_winner", 64'(p), 64'(m_exp));
      idx = int'(rq_addr[p][9:2]);
      m_acc[p]++;
      if (!ref_warm[idx]) m_miss[p]++;
      ref_warm[idx] = 1'b1;
      if (rq_we[p]) ref_mem[idx] = rq_wdata[p];
      else chk("rand_rdata", rdata, ref_mem[idx]);
      chk("rand_p0_cnts", {p0_acc_cnt, p0_miss_cnt}, {32'(m_acc[0]), 32'(m_miss[0])});
      chk("rand_p1_cnts", {p1_acc_cnt, p1_miss_cnt}, {32'(m_acc[1]), 32'(m_miss[1])});
      m_last = p; m_pending = 1;
    end else if (m_pending != 0 && (p0_valid || p1_valid)) begin
      m_exp = (p0_valid && p1_valid) ? 1 - m_last : (p0_valid ? 0 : 1);
      m_pending = 0;
    end
  endtask

  task automatic requester(input int p, input int n);
    for (int t = 0; t < n; t++) begin
      int gap;
      logic got;
      rq_addr[p]  = 32'($urandom_range(0, 15)) << 4;
      rq_we[p]    = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      rq_wdata[p] = $urandom;
      if (p == 1) begin
        p1_valid = 1'b1; p1_we = rq_we[p]; p1_addr = rq_addr[p]; p1_wdata = rq_wdata[p];
      end else begin
        p0_valid = 1'b1; p0_addr = rq_addr[p];
      end
      got = 1'b0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if ((p == 1) ? p1_done : p0_done) begin
          got = 1'b1;
          break;
        end
      end
      chk("rand_done_seen", {63'b0, got}, 64'd1);
      if (!got) break;
      @(posedge clk); #1;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        if (p == 1) p1_valid = 1'b0; else p0_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    if (p == 1) p1_valid = 1'b0; else p0_valid = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    int          p0a, p0m, p1a, p1m;
  } vec_t;

  initial begin
    vec_t        vecs [8];
    int          lat, rc, k, cnt, order [4];
    logic [31:0] rd;
    logic        bad, got;

    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,         2, 32'hC0DE_0010, 1, 0, 0, 0};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF,  5, 32'h0,         1, 0, 1, 1};
    vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,         2, 32'hDEADBEEF,  1, 0, 2, 1};
    vecs[3] = '{1'b0, 1'b0, 32'h80,  32'h0,         5, 32'hC0DE_0020, 2, 1, 2, 1};
    vecs[4] = '{1'b0, 1'b0, 32'h80,  32'h0,         2, 32'hC0DE_0020, 3, 1, 2, 1};
    vecs[5] = '{1'b1, 1'b0, 32'h40,  32'h0,         2, 32'hC0DE_0010, 3, 1, 3, 1};
    vecs[6] = '{1'b1, 1'b1, 32'h40,  32'h12345678,  2, 32'h0,         3, 1, 4, 1};
    vecs[7] = '{1'b0, 1'b0, 32'h40,  32'h0,         2, 32'h12345678,  4, 1, 4, 1};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl_outputs", {60'b0, p0_done, p1_done, c_rd_req, c_wr_req}, 64'd0);
    chk("rst_c_addr_wdata", {c_addr, c_wr_data}, 64'd0);
    chk("rst_rdata", {32'b0, rdata}, 64'd0);
    chk("rst_p0_cnts", {p0_acc_cnt, p0_miss_cnt}, 64'd0);
    chk("rst_p1_cnts", {p1_acc_cnt, p1_miss_cnt}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Saturation of a 4-bit counter, then clear against a simultaneous increment
    @(posedge clk); #1 s_p0_valid = 1'b1;
    cnt = 0;
    for (k = 0; k < 200 && cnt < 20; k++) begin
      @(negedge clk);
      if (s_p0_done) cnt++;
    end
    chk("sat_done_count", 64'(cnt), 64'd20);
    chk("sat_acc_cnt", 64'(s_p0_acc), 64'd15);
    chk("sat_miss_cnt", 64'(s_p0_miss), 64'd0);
    @(posedge clk);
    @(posedge clk); #1 s_cnt_clr = 1'b1;
    @(posedge clk); #1 s_cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_vs_inc", 64'(s_p0_acc), 64'd0);
    @(posedge clk); #1;
    got = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_p0_done) begin got = 1'b1; break; end
    end
    chk("post_clr_done", {63'b0, got}, 64'd1);
    chk("post_clr_acc", 64'(s_p0_acc), 64'd1);
    @(posedge clk); #1 s_p0_valid = 1'b0;

    // Directed single accesses from IDLE
    do_reset();
    preload(8'd16);
    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rc, rd);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_req_cycles", i), 64'(rc), 64'(vecs[i].lat - 1));
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), {32'b0, rd}, {32'b0, vecs[i].rdata});
      chk($sformatf("vec%0d_p0_cnts", i), {p0_acc_cnt, p0_miss_cnt}, {32'(vecs[i].p0a), 32'(vecs[i].p0m)});
      chk($sformatf("vec%0d_p1_cnts", i), {p1_acc_cnt, p1_miss_cnt}, {32'(vecs[i].p1a), 32'(vecs[i].p1m)});
    end

    // Address change on port 1 during a miss is ignored
    @(posedge clk); #1;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h200;
    for (k = 0; k < 20 && !c_rd_req; k++) @(negedge clk);
    @(posedge clk); #1 p1_addr = 32'h300;
    bad = 1'b0; got = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (c_addr != 32'h200) bad = 1'b1;
      if (p1_done) begin got = 1'b1; rd = rdata; break; end
    end
    chk("addr_hold_stable", {63'b0, bad}, 64'd0);
    chk("addr_hold_done", {63'b0, got}, 64'd1);
    chk("addr_hold_rdata", {32'b0, rd}, {32'b0, 32'hC0DE_0080});
    @(posedge clk); #1 p1_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Reset asserted while a miss is in progress
    #1 p0_valid = 1'b1; p0_addr = 32'h300;
    got = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (c_rd_req && c_miss) begin got = 1'b1; break; end
    end
    chk("rst_mid_in_miss", {63'b0, got}, 64'd1);
    rst_n = 1'b0; p0_valid = 1'b0;
    #1;
    chk("rst_mid_req_drop", {62'b0, c_rd_req, c_wr_req}, 64'd0);
    chk("rst_mid_p0_cnts", {p0_acc_cnt, p0_miss_cnt}, 64'd0);
    chk("rst_mid_p1_cnts", {p1_acc_cnt, p1_miss_cnt}, 64'd0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (p0_done || p1_done) bad = 1'b1;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    if (p0_done || p1_done) bad = 1'b1;
    chk("rst_mid_no_done", {63'b0, bad}, 64'd0);
    do_access(1'b0, 1'b0, 32'h300, 32'h0, lat, rc, rd);
    chk("rst_after_latency", 64'(lat), 64'd5);
    chk("rst_after_rdata", {32'b0, rd}, {32'b0, 32'hC0DE_00C0});
    chk("rst_after_p0_cnts", {p0_acc_cnt, p0_miss_cnt}, {32'd1, 32'd1});

    // Simultaneous requests after reset, both held: grants alternate starting with port 0
    do_reset();
    preload(8'd16);
    preload(8'd32);
    @(posedge clk); #1;
    p0_valid = 1'b1; p0_addr = 32'h40;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      order[i] = -1;
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (p0_done || p1_done) begin order[i] = p1_done ? 1 : 0; break; end
      end
    end
    @(posedge clk); #1 p0_valid = 1'b0; p1_valid = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i % 2));
    repeat (2) @(posedge clk);

    // Randomized two-requester run against the reference model
    do_reset();
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = init_word(i); ref_warm[i] = 1'b0;
    end
    m_acc[0] = 0; m_acc[1] = 0; m_miss[0] = 0; m_miss[1] = 0;
    m_last = 1; m_exp = 0; m_pending = 1; req_fin = 0;
    @(posedge clk); #1;
    fork
      begin requester(0, 30); req_fin++; end
      begin requester(1, 30); req_fin++; end
      begin
        while (req_fin < 2) begin
          @(negedge clk);
          monitor_step();
        end
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
